sprite_anim_render: RTL and testbench
=====================================

Name: sprite_anim_render

Overview:
Parametrised, pipelined sprite pixel generator. It is the successor to the per-character combinational sprite selectors.
- Serves one sprite of SPR_W x SPR_H pixels with NFRAMES animation frames stored back-to-back in a single synchronous ROM.
- Sequences the frames itself from a per-video-frame tick.
- Supports horizontal mirroring.
- Returns alpha-keyed 12-bit RGB, aligned with a delayed pixel-valid, to the scene compositor.

Parameters:
SPR_W, 88, sprite width in pixels
SPR_H, 94, sprite height in pixels
NFRAMES, 4, animation frames in ROM (>=1)
ADDR_W, 16, ROM address width; must satisfy NFRAMES*SPR_W*SPR_H <= 2^ADDR_W
ROM_LAT, 1, synchronous ROM read latency in cycles (1 or 2)
HOLD_TICKS, 6, frame_tick pulses per animation frame (>=1)
ALPHA_MIN, 4'hF, minimum alpha nibble for an opaque pixel

Ports:
clk  in  1  pixel clock
rst  in  1  asynchronous reset, active-high
pix_valid  in  1  x/y is a visible pixel this cycle
x  in  10  current pixel column
y  in  10  current pixel row
spr_x  in  10  sprite left edge
spr_y  in  9  sprite top edge
anim_mode  in  2  0=static frame0, 1=loop, 2=one-shot, 3=freeze
mirror  in  1  horizontal flip
frame_tick  in  1  one-cycle pulse once per video frame (vsync)
rom_addr  out  ADDR_W  registered ROM address
rom_data  in  16  ROM word: [15:4] RGB, [3:0] alpha
out_valid  out  1  pix_valid delayed by L
isempty  out  1  1 = transparent or outside sprite
rgb  out  12  pixel colour; 0 when isempty
anim_frame  out  log2(NFRAMES) (min 1)  frame currently displayed
anim_done  out  1  one-shot sequence finished

Behaviour:
- Reset (async, rst=1): all registers, pipeline contents and outputs are 0; FSM in IDLE; anim_frame=0.
- Hit test (stage 0):
  - Uses 11-bit arithmetic. The window is half-open: spr_x <= x < spr_x+SPR_W and spr_y <= y < spr_y+SPR_H.
  - A window extending past 1023 produces no wrap-around hits.
- Address:
  - col = mirror ? SPR_W-1-(x-spr_x) : x-spr_x.
  - row = SPR_H-1-(y-spr_y); ROM rows are stored bottom-up.
  - rom_addr <= frame_q*SPR_W*SPR_H + row*SPR_W + col.
  - rom_addr is registered at the end of cycle 0. It holds its previous value when there is no hit.
- Pipeline:
  - hit and pix_valid are shifted alongside the address.
  - Total latency L = 1+ROM_LAT cycles from x/y/pix_valid to out_valid/isempty/rgb.
  - There are no stalls; the pipeline accepts one pixel per cycle.
- Output:
  - isempty = ~valid_d | ~hit_d | (rom_data[3:0] < ALPHA_MIN).
  - rgb = isempty ? 0 : rom_data[15:4].
  - Outputs are registered.
- frame_q:
  - Updated only on a frame_tick cycle, so the displayed frame never changes mid-scan.
  - anim_mode and mirror are used combinationally.
- FSM states:
  - IDLE: mode 0, frame 0.
  - RUN: mode 1 or 2 advancing.
  - DONE: mode 2 finished.
  - FROZEN: mode 3.
- FSM evaluation on each frame_tick:
  - Mode change (anim_mode != mode_q): mode_q<=anim_mode and tick_cnt<=0. Modes 0, 1 and 2 also set frame<=0 and enter IDLE/RUN/RUN respectively. Mode 3 keeps the current frame and enters FROZEN. anim_done<=0.
  - RUN: tick_cnt increments. At tick_cnt=HOLD_TICKS-1, tick_cnt<=0 and the frame advances.
    - Mode 1: frame wraps NFRAMES-1 -> 0.
    - Mode 2: reaching frame NFRAMES-1 enters DONE with anim_done=1.
  - DONE: holds the last frame. anim_done stays 1 until a mode change.
  - IDLE/FROZEN: no counting.
- Without frame_tick, anim_mode changes have no effect on the FSM.
- NFRAMES=1: loop and one-shot stay on frame 0. One-shot enters DONE after HOLD_TICKS ticks.
- rst asserted mid-line: outputs drop to 0 immediately. The first valid output after release appears L cycles after the next pix_valid.

Test Plan:
1. Defaults, ROM_LAT=1, spr_x=100, spr_y=200, x=100, y=200, mirror=0, frame 0 -> rom_addr=8184 after 1 cycle; out_valid=1 with rgb=rom_data[15:4] 2 cycles after input when alpha=F.
2. Same pixel with mirror=1 -> rom_addr=8271. Alpha=E -> isempty=1, rgb=0.
3. Boundary pixels:
   - x=187,y=293 -> hit, addr 87.
   - x=188 or y=294 -> isempty=1 regardless of rom_data.
   - spr_x=1000 -> x=1023 hits and x=0 does not.
4. anim_mode=1, 6 ticks -> frame 1; frame-1 pixel addr=8272+8184=16456; 24 ticks -> frame 0.
5. anim_mode=2 -> frame 3 with anim_done=1 after 18 ticks; 30 more ticks leave it unchanged. Switching to mode 1 on the next tick -> frame 0, anim_done=0.
6. Mode 3 at frame 2 -> frame stays 2 for 12 ticks. Pulse rst mid-stream -> out_valid/rgb/anim_frame=0 the same cycle, without waiting for a clk edge.

Source files
------------

// File: rtl/sprite_anim_render.sv
// Pipelined sprite pixel generator: hit test, bottom-up ROM addressing,
// alpha keying and a tick-driven animation sequencer.
module sprite_anim_render #(
  parameter int          SPR_W      = 88,
  parameter int          SPR_H      = 94,
  parameter int          NFRAMES    = 4,
  parameter int          ADDR_W     = 16,
  parameter int          ROM_LAT    = 1,
  parameter int          HOLD_TICKS = 6,
  parameter logic [3:0]  ALPHA_MIN  = 4'hF,
  localparam int         FW = (NFRAMES > 1) ? $clog2(NFRAMES) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              pix_valid_i,
  input  logic [9:0]        x_i,
  input  logic [9:0]        y_i,
  input  logic [9:0]        spr_x_i,
  input  logic [8:0]        spr_y_i,
  input  logic [1:0]        anim_mode_i,
  input  logic              mirror_i,
  input  logic              frame_tick_i,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [15:0]       rom_data_i,
  output logic              out_valid_o,
  output logic              isempty_o,
  output logic [11:0]       rgb_o,
  output logic [FW-1:0]     anim_frame_o,
  output logic              anim_done_o
);

  localparam int FSZ = SPR_W * SPR_H;
  localparam int TW  = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
  localparam logic [FW-1:0] LASTF = FW'(NFRAMES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE, FROZEN} state_t;

  state_t              state_q;
  logic [1:0]          mode_q;
  logic [TW-1:0]       tick_q;
  logic [FW-1:0]       frame_q, frame_nxt;
  logic                done_q;

  logic [10:0]         x11, y11, sx11, sy11, dx, dy;
  logic                hit;
  logic [ADDR_W-1:0]   col, row, addr_d, rom_addr_q;
  logic [ROM_LAT-1:0]  vld_q, hit_q;
  logic                empty_d;
  logic [11:0]         rgb_d;
  logic                out_valid_q, isempty_q;
  logic [11:0]         rgb_q;

  // 11-bit compare so a window past column 1023 never wraps to 0
  always_comb begin
    x11  = {1'b0, x_i};
    y11  = {1'b0, y_i};
    sx11 = {1'b0, spr_x_i};
    sy11 = {2'b0, spr_y_i};
    dx   = x11 - sx11;
    dy   = y11 - sy11;
    hit  = (x11 >= sx11) && (x11 < sx11 + 11'(SPR_W)) &&
           (y11 >= sy11) && (y11 < sy11 + 11'(SPR_H));
    col  = mirror_i ? ADDR_W'(SPR_W - 1) - ADDR_W'(dx) : ADDR_W'(dx);
    row  = ADDR_W'(SPR_H - 1) - ADDR_W'(dy);
    addr_d = ADDR_W'(frame_q) * ADDR_W'(FSZ) +
             row * ADDR_W'(SPR_W) + col;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rom_addr_q <= '0;
      vld_q      <= '0;
      hit_q      <= '0;
    end else begin
      if (hit) rom_addr_q <= addr_d;
      vld_q[0] <= pix_valid_i;
      hit_q[0] <= hit;
      for (int i = 1; i < ROM_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        hit_q[i] <= hit_q[i-1];
      end
    end
  end

  always_comb begin
    empty_d = ~vld_q[ROM_LAT-1] | ~hit_q[ROM_LAT-1] |
              (rom_data_i[3:0] < ALPHA_MIN);
    rgb_d   = empty_d ? 12'h000 : rom_data_i[15:4];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_valid_q <= 1'b0;
      isempty_q   <= 1'b0;
      rgb_q       <= '0;
    end else begin
      out_valid_q <= vld_q[ROM_LAT-1];
      isempty_q   <= empty_d;
      rgb_q       <= rgb_d;
    end
  end

  assign frame_nxt = frame_q + FW'(1);

  // Sequencer only moves on frame_tick, so a scan never sees two frames
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      mode_q  <= 2'd0;
      tick_q  <= '0;
      frame_q <= '0;
      done_q  <= 1'b0;
    end else if (frame_tick_i) begin
      if (anim_mode_i != mode_q) begin
        mode_q <= anim_mode_i;
        tick_q <= '0;
        done_q <= 1'b0;
        unique case (anim_mode_i)
          2'd0: begin
            frame_q <= '0;
            state_q <= IDLE;
          end
          2'd3: state_q <= FROZEN;
          default: begin
            frame_q <= '0;
            state_q <= RUN;
          end
        endcase
      end else if (state_q == RUN) begin
        if (tick_q == TW'(HOLD_TICKS - 1)) begin
          tick_q <= '0;
          if (mode_q == 2'd1) begin
            frame_q <= (frame_q == LASTF) ? '0 : frame_nxt;
          end else if (frame_q == LASTF) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            frame_q <= frame_nxt;
            if (frame_nxt == LASTF) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end else begin
          tick_q <= tick_q + TW'(1);
        end
      end
    end
  end

  assign rom_addr_o   = rom_addr_q;
  assign out_valid_o  = out_valid_q;
  assign isempty_o    = isempty_q;
  assign rgb_o        = rgb_q;
  assign anim_frame_o = frame_q;
  assign anim_done_o  = done_q;

endmodule

// File: tb/tb_sprite_anim_render.sv
// Scoreboard bench for sprite_anim_render: per-pixel expectations queued
// at drive time, popped when the pipeline delivers them.
module tb_sprite_anim_render;

  logic        clk = 1'b0;
  logic        rst;
  logic        pix_valid;
  logic [9:0]  x, y, spr_x;
  logic [8:0]  spr_y;
  logic [1:0]  anim_mode;
  logic        mirror;
  logic        frame_tick;
  logic [15:0] rom_addr;
  logic [15:0] rom_data;
  logic        out_valid, isempty;
  logic [11:0] rgb;
  logic [1:0]  anim_frame;
  logic        anim_done;

  logic [3:0]  alpha_v;

  always #5 clk = ~clk;

  // ROM model: colour derived from the address, alpha set by the bench
  assign rom_data = {rom_addr[11:0] ^ 12'h5A3, alpha_v};

  sprite_anim_render dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .pix_valid_i  (pix_valid),
    .x_i          (x),
    .y_i          (y),
    .spr_x_i      (spr_x),
    .spr_y_i      (spr_y),
    .anim_mode_i  (anim_mode),
    .mirror_i     (mirror),
    .frame_tick_i (frame_tick),
    .rom_addr_o   (rom_addr),
    .rom_data_i   (rom_data),
    .out_valid_o  (out_valid),
    .isempty_o    (isempty),
    .rgb_o        (rgb),
    .anim_frame_o (anim_frame),
    .anim_done_o  (anim_done)
  );

  typedef struct {
    logic        v;
    logic        e;
    logic [11:0] rgb;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   sx, sy, efr;
  logic mir;
  logic pend_hit;
  int   pend_addr;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input int px, input int py,
                      input logic ft);
    exp_t e;
    int   a;
    logic h;
    @(negedge clk);
    if (pend_hit) chk("rom_addr", 32'(rom_addr), pend_addr);
    if (q.size() >= 2) begin
      e = q.pop_front();
      chk("out_valid", 32'(out_valid), 32'(e.v));
      chk("isempty", 32'(isempty), 32'(e.e));
      chk("rgb", 32'(rgb), 32'(e.rgb));
    end
    pix_valid  = v;
    x          = 10'(px);
    y          = 10'(py);
    frame_tick = ft;
    spr_x      = 10'(sx);
    spr_y      = 9'(sy);
    mirror     = mir;
    h = (px >= sx) && (px < sx + 88) && (py >= sy) && (py < sy + 94);
    a = efr * 8272 + (93 - (py - sy)) * 88 +
        (mir ? 87 - (px - sx) : px - sx);
    e.v   = v;
    e.e   = !v || !h || (alpha_v < 4'hF);
    e.rgb = e.e ? 12'h000 : (a[11:0] ^ 12'h5A3);
    q.push_back(e);
    pend_hit  = h;
    pend_addr = a;
  endtask

  task automatic flush();
    step(1'b0, 0, 0, 1'b0);
    step(1'b0, 0, 0, 1'b0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 0, 0, 1'b1);
      step(1'b0, 0, 0, 1'b0);
    end
  endtask

  task automatic chk_anim(input string tag, input int fr, input logic dn);
    chk({tag, "_frame"}, 32'(anim_frame), fr);
    chk({tag, "_done"}, 32'(anim_done), 32'(dn));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; pix_valid = 1'b0; x = '0; y = '0;
    spr_x = '0; spr_y = '0; anim_mode = 2'd0; mirror = 1'b0;
    frame_tick = 1'b0; alpha_v = 4'hF;
    sx = 100; sy = 200; efr = 0; mir = 1'b0; pend_hit = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_empty", 32'(isempty), 0);
    chk("rst_rgb", 32'(rgb), 0);
    chk("rst_addr", 32'(rom_addr), 0);
    chk_anim("rst", 0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // corners and edges of the window
    step(1'b1, 100, 200, 1'b0);
    step(1'b1, 187, 293, 1'b0);
    step(1'b1, 188, 293, 1'b0);
    step(1'b1, 187, 294, 1'b0);
    step(1'b1, 150, 250, 1'b0);
    step(1'b1,  99, 250, 1'b0);
    step(1'b0, 120, 220, 1'b0);
    flush();

    mir = 1'b1;
    step(1'b1, 100, 200, 1'b0);
    step(1'b1, 130, 260, 1'b0);
    flush();
    alpha_v = 4'hE;
    step(1'b1, 100, 200, 1'b0);
    flush();
    alpha_v = 4'hF;
    mir = 1'b0;

    sx = 1000;
    step(1'b1, 1023, 200, 1'b0);
    step(1'b1,    0, 200, 1'b0);
    step(1'b1,  999, 200, 1'b0);
    flush();
    sx = 100;

    anim_mode = 2'd1;
    step(1'b0, 0, 0, 1'b0);
    chk_anim("nochange", 0, 1'b0);
    ticks(1);
    chk_anim("loop0", 0, 1'b0);
    ticks(6);
    chk_anim("loop1", 1, 1'b0);
    efr = 1;
    step(1'b1, 100, 200, 1'b0);
    flush();
    ticks(18);
    chk_anim("loopwrap", 0, 1'b0);
    efr = 0;

    anim_mode = 2'd2;
    ticks(1);
    chk_anim("shot0", 0, 1'b0);
    ticks(17);
    chk_anim("shot17", 2, 1'b0);
    ticks(1);
    chk_anim("shot18", 3, 1'b1);
    efr = 3;
    step(1'b1, 140, 230, 1'b0);
    flush();
    ticks(30);
    chk_anim("shothold", 3, 1'b1);
    anim_mode = 2'd1;
    repeat (3) step(1'b0, 0, 0, 1'b0);
    chk_anim("notick", 3, 1'b1);
    ticks(1);
    chk_anim("reloop", 0, 1'b0);
    efr = 0;

    ticks(12);
    chk_anim("loop2", 2, 1'b0);
    anim_mode = 2'd3;
    ticks(1);
    chk_anim("frz", 2, 1'b0);
    ticks(12);
    chk_anim("frzhold", 2, 1'b0);
    efr = 2;
    step(1'b1, 100, 200, 1'b0);
    step(1'b1, 110, 210, 1'b0);
    step(1'b1, 120, 220, 1'b0);
    @(posedge clk);
    #2;
    chk("pre_rst_valid", 32'(out_valid), 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_rgb", 32'(rgb), 0);
    chk_anim("mid_rst", 0, 1'b0);
    q.delete();
    pend_hit = 1'b0;
    anim_mode = 2'd0;
    efr = 0;
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 0, 0, 1'b0);
    step(1'b1, 100, 200, 1'b0);
    step(1'b1, 187, 293, 1'b0);
    step(1'b0, 0, 0, 1'b0);
    flush();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
